// File: rtl/dds_wb_regs.sv
// Wishbone classic responder and configuration register bank for the DDS core.
// Holds the waveform configuration registers and raises READY after a fixed post-reset interval.
module dds_wb_regs #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int INIT_CYCLES = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  ready_o,
  output logic                  enable_o,
  output logic [1:0]            dds_src_o,
  output logic [15:0]           tuning_word_o,
  output logic [1:0]            gain_o,
  output logic [15:0]           offset_o,
  output logic                  cfg_update_o
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_READY  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ENABLE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SRC    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TUNING = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_GAIN   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OFFSET = ADDR_WIDTH'(5);

  logic [CNT_W-1:0]      init_cnt_r;
  logic                  accept_s;
  logic                  wr_commit_s;
  logic                  cfg_addr_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // A strobe is taken only while no ack is outstanding, so a held strobe yields one ack.
  assign accept_s    = wb_stb_i & ~wb_ack_o;
  assign wr_commit_s = accept_s & wb_we_i & ready_o;

  // Read-data mux and config-address decode; unmapped addresses read zero.
  always_comb begin
    rd_data_s  = {DATA_WIDTH{1'b0}};
    cfg_addr_s = 1'b0;
    case (wb_addr_i)
      ADDR_READY:  rd_data_s = DATA_WIDTH'(ready_o);
      ADDR_ENABLE: begin
        rd_data_s  = DATA_WIDTH'(enable_o);
        cfg_addr_s = 1'b1;
      end
      ADDR_SRC: begin
        rd_data_s  = DATA_WIDTH'(dds_src_o);
        cfg_addr_s = 1'b1;
      end
      ADDR_TUNING: begin
        rd_data_s  = DATA_WIDTH'(tuning_word_o);
        cfg_addr_s = 1'b1;
      end
      ADDR_GAIN: begin
        rd_data_s  = DATA_WIDTH'(gain_o);
        cfg_addr_s = 1'b1;
      end
      ADDR_OFFSET: begin
        rd_data_s  = DATA_WIDTH'(offset_o);
        cfg_addr_s = 1'b1;
      end
      default: begin
        rd_data_s  = {DATA_WIDTH{1'b0}};
        cfg_addr_s = 1'b0;
      end
    endcase
  end

  // Post-reset init counter; READY sets on the edge the count reaches INIT_CYCLES.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      init_cnt_r <= {CNT_W{1'b0}};
      ready_o    <= 1'b0;
    end else if (init_cnt_r != CNT_W'(INIT_CYCLES)) begin
      init_cnt_r <= init_cnt_r + CNT_W'(1);
      if (init_cnt_r == CNT_W'(INIT_CYCLES - 1)) begin
        ready_o <= 1'b1;
      end
    end
  end

  // Bus handshake: registered ack, read data capture and the config-update pulse.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= {DATA_WIDTH{1'b0}};
      cfg_update_o <= 1'b0;
    end else begin
      wb_ack_o     <= accept_s;
      cfg_update_o <= wr_commit_s & cfg_addr_s;
      if (accept_s & ~wb_we_i) begin
        wb_dat_o <= rd_data_s;
      end
    end
  end

  // Configuration registers; only implemented field bits are stored.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      enable_o      <= 1'b0;
      dds_src_o     <= 2'd0;
      tuning_word_o <= 16'h0001;
      gain_o        <= 2'd0;
      offset_o      <= 16'h00FF;
    end else if (wr_commit_s) begin
      case (wb_addr_i)
        ADDR_ENABLE: enable_o      <= wb_dat_i[0];
        ADDR_SRC:    dds_src_o     <= wb_dat_i[1:0];
        ADDR_TUNING: tuning_word_o <= wb_dat_i[15:0];
        ADDR_GAIN:   gain_o        <= wb_dat_i[1:0];
        ADDR_OFFSET: offset_o      <= wb_dat_i[15:0];
        default:     enable_o      <= enable_o;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_wb_regs.sv
// Self-checking bench for dds_wb_regs: directed vector table, multi-cycle corner cases
// and randomized bus traffic checked against an array-based register model.
module tb_dds_wb_regs;

  localparam int INIT = 4;

  logic        wb_clk_i_tb = 1'b0;
  logic        wb_rst_i_tb;
  logic [31:0] wb_dat_i_tb = 32'd0;
  logic [15:0] wb_addr_i_tb = 16'd0;
  logic        wb_we_i_tb = 1'b0;
  logic        wb_stb_i_tb = 1'b0;
  logic [31:0] wb_dat_o_tb;
  logic        wb_ack_o_tb;
  logic        ready_tb;
  logic        enable_tb;
  logic [1:0]  dds_src_tb;
  logic [15:0] tuning_tb;
  logic [1:0]  gain_tb;
  logic [15:0] offset_tb;
  logic        cfg_update_tb;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] model [0:7];
  logic [31:0] mask  [0:7];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:28];

  dds_wb_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .INIT_CYCLES(INIT)) dut (
    .wb_clk_i(wb_clk_i_tb), .wb_rst_i(wb_rst_i_tb), .wb_dat_i(wb_dat_i_tb),
    .wb_addr_i(wb_addr_i_tb), .wb_we_i(wb_we_i_tb), .wb_stb_i(wb_stb_i_tb),
    .wb_dat_o(wb_dat_o_tb), .wb_ack_o(wb_ack_o_tb), .ready_o(ready_tb),
    .enable_o(enable_tb), .dds_src_o(dds_src_tb), .tuning_word_o(tuning_tb),
    .gain_o(gain_tb), .offset_o(offset_tb), .cfg_update_o(cfg_update_tb)
  );

  always #5 wb_clk_i_tb = ~wb_clk_i_tb;

  // Clock edges elapsed since reset release; READY is expected once this reaches INIT.
  always @(posedge wb_clk_i_tb or posedge wb_rst_i_tb) begin
    if (wb_rst_i_tb) cyc <= 0;
    else             cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 32'd0;
    model[3] = 32'h0000_0001;
    model[5] = 32'h0000_00FF;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a, input bit rdy);
    if (a == 16'd0)     return {31'd0, rdy};
    else if (a <= 16'd5) return model[a[2:0]];
    else                return 32'd0;
  endfunction

  task automatic check_outputs();
    chk("ready_o",       {31'd0, ready_tb},      (cyc >= INIT) ? 32'd1 : 32'd0);
    chk("enable_o",      {31'd0, enable_tb},     model[1]);
    chk("dds_src_o",     {30'd0, dds_src_tb},    model[2]);
    chk("tuning_word_o", {16'd0, tuning_tb},     model[3]);
    chk("gain_o",        {30'd0, gain_tb},       model[4]);
    chk("offset_o",      {16'd0, offset_tb},     model[5]);
  endtask

  // Single bus transfer: start with no ack outstanding, wait (bounded) for the ack.
  task automatic bus_xfer(input bit we, input logic [15:0] a, input logic [31:0] d,
                          output bit rdy_at_accept);
    int n;
    @(negedge wb_clk_i_tb);
    while (wb_ack_o_tb) @(negedge wb_clk_i_tb);
    rdy_at_accept = (cyc >= INIT);
    wb_addr_i_tb = a; wb_dat_i_tb = d; wb_we_i_tb = we; wb_stb_i_tb = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk_i_tb); #1; n++;
    end while (!wb_ack_o_tb && n < 8);
    wb_stb_i_tb = 1'b0; wb_we_i_tb = 1'b0;
    chk(we ? "wr_ack" : "rd_ack", {31'd0, wb_ack_o_tb}, 32'd1);
  endtask

  task automatic wb_write(input logic [15:0] a, input logic [31:0] d);
    bit rdy;
    bit hit;
    bus_xfer(1'b1, a, d, rdy);
    hit = rdy && (a >= 16'd1) && (a <= 16'd5);
    if (hit) model[a[2:0]] = d & mask[a[2:0]];
    chk("wr_cfg_update", {31'd0, cfg_update_tb}, {31'd0, hit});
    check_outputs();
    @(posedge wb_clk_i_tb); #1;
    chk("wr_ack_drop", {31'd0, wb_ack_o_tb}, 32'd0);
    chk("wr_cfg_drop", {31'd0, cfg_update_tb}, 32'd0);
  endtask

  task automatic wb_read(input logic [15:0] a, output logic [31:0] rd, output logic [31:0] exp);
    bit rdy;
    bus_xfer(1'b0, a, 32'd0, rdy);
    rd  = wb_dat_o_tb;
    exp = model_read(a, rdy);
    chk("rd_cfg_update", {31'd0, cfg_update_tb}, 32'd0);
  endtask

  task automatic do_reset();
    wb_stb_i_tb = 1'b0; wb_we_i_tb = 1'b0;
    wb_rst_i_tb = 1'b1;
    repeat (5) @(negedge wb_clk_i_tb);
    model_reset();
    wb_rst_i_tb = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, exp;
    int n;
    wb_rst_i_tb = 1'b1;
    mask[0] = 32'd0; mask[1] = 32'h1; mask[2] = 32'h3; mask[3] = 32'hFFFF;
    mask[4] = 32'h3; mask[5] = 32'hFFFF; mask[6] = 32'd0; mask[7] = 32'd0;

    for (int i = 1; i <= 5; i++)
      vecs[i - 1] = '{1'b0, 16'(i), 32'd0, (i == 3) ? 32'h1 : (i == 5) ? 32'hFF : 32'd0};
    for (int i = 0; i <= 5; i++) begin
      vecs[5 + i]  = '{1'b1, 16'(i), 32'hFFFF_FFFF, 32'd0};
      vecs[17 + i] = '{1'b1, 16'(i), 32'h0000_0000, 32'd0};
    end
    vecs[11] = '{1'b0, 16'd0, 32'd0, 32'h1};
    vecs[12] = '{1'b0, 16'd1, 32'd0, 32'h1};
    vecs[13] = '{1'b0, 16'd2, 32'd0, 32'h3};
    vecs[14] = '{1'b0, 16'd3, 32'd0, 32'hFFFF};
    vecs[15] = '{1'b0, 16'd4, 32'd0, 32'h3};
    vecs[16] = '{1'b0, 16'd5, 32'd0, 32'hFFFF};
    for (int i = 0; i <= 5; i++)
      vecs[23 + i] = '{1'b0, 16'(i), 32'd0, (i == 0) ? 32'h1 : 32'd0};

    do_reset();
    chk("rst_ack", {31'd0, wb_ack_o_tb}, 32'd0);
    chk("rst_dat", wb_dat_o_tb, 32'd0);
    chk("rst_cfg_update", {31'd0, cfg_update_tb}, 32'd0);
    check_outputs();

    // Write before READY: acked but dropped.
    wb_write(16'd1, 32'h1);
    chk("early_enable", {31'd0, enable_tb}, 32'd0);

    n = 0;
    do begin
      wb_read(16'd0, rd, exp);
      chk("poll_ready", rd, exp);
      n++;
    end while (rd != 32'd1 && n < 20);
    chk("poll_ready_final", rd, 32'd1);

    for (int i = 0; i < 29; i++) begin
      if (vecs[i].we) begin
        wb_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        wb_read(vecs[i].addr, rd, exp);
        chk($sformatf("vec%0d_rd_a%0d", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end

    // Strobe held past the ack: exactly one ack and one config pulse.
    @(negedge wb_clk_i_tb);
    while (wb_ack_o_tb) @(negedge wb_clk_i_tb);
    wb_addr_i_tb = 16'd3; wb_dat_i_tb = 32'hA5A5_BEEF; wb_we_i_tb = 1'b1; wb_stb_i_tb = 1'b1;
    @(posedge wb_clk_i_tb); #1;
    chk("hold_ack1", {31'd0, wb_ack_o_tb}, 32'd1);
    chk("hold_cfg1", {31'd0, cfg_update_tb}, 32'd1);
    @(posedge wb_clk_i_tb); #1;
    chk("hold_ack2", {31'd0, wb_ack_o_tb}, 32'd0);
    chk("hold_cfg2", {31'd0, cfg_update_tb}, 32'd0);
    wb_stb_i_tb = 1'b0; wb_we_i_tb = 1'b0;
    @(posedge wb_clk_i_tb); #1;
    chk("hold_ack3", {31'd0, wb_ack_o_tb}, 32'd0);
    chk("hold_cfg3", {31'd0, cfg_update_tb}, 32'd0);
    model[3] = 32'h0000_BEEF;
    check_outputs();

    // Unmapped address 7.
    wb_write(16'd7, 32'hFFFF_FFFF);
    wb_read(16'd7, rd, exp);
    chk("unmapped_rd", rd, 32'd0);

    for (int i = 0; i < 150; i++) begin
      int sel;
      logic [15:0] a;
      sel = $urandom_range(0, 9);
      a = (sel == 8) ? 16'h0103 : (sel == 9) ? 16'hFFFF : 16'(sel);
      if ($urandom_range(0, 1) == 1) begin
        wb_write(a, $urandom);
      end else begin
        wb_read(a, rd, exp);
        chk($sformatf("rand_rd_a%0h", a), rd, exp);
      end
    end

    // Reset while an OFFSET write ack is high.
    @(negedge wb_clk_i_tb);
    while (wb_ack_o_tb) @(negedge wb_clk_i_tb);
    wb_addr_i_tb = 16'd5; wb_dat_i_tb = 32'h0000_1234; wb_we_i_tb = 1'b1; wb_stb_i_tb = 1'b1;
    @(posedge wb_clk_i_tb); #1;
    chk("midrst_ack_before", {31'd0, wb_ack_o_tb}, 32'd1);
    chk("midrst_offset_before", {16'd0, offset_tb}, 32'h1234);
    #1;
    wb_rst_i_tb = 1'b1; wb_stb_i_tb = 1'b0; wb_we_i_tb = 1'b0;
    #1;
    model_reset();
    chk("midrst_ack", {31'd0, wb_ack_o_tb}, 32'd0);
    chk("midrst_cfg_update", {31'd0, cfg_update_tb}, 32'd0);
    check_outputs();
    @(negedge wb_clk_i_tb);
    @(negedge wb_clk_i_tb);
    wb_rst_i_tb = 1'b0;
    for (int k = 1; k <= INIT + 1; k++) begin
      @(posedge wb_clk_i_tb); #1;
      chk($sformatf("reinit_ready_k%0d", k), {31'd0, ready_tb}, (k >= INIT) ? 32'd1 : 32'd0);
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dds_wb_regs.md
Name: dds_wb_regs

Overview:
- Wishbone responder and configuration register bank for the DDS core.
- Decodes single-cycle Wishbone classic accesses and acknowledges each strobe with exactly one registered ack pulse.
- Holds the ENABLE, DDS_SRC, TUNING_WORD, GAIN_WORD and OFFSET_WORD registers and drives them to the waveform datapath.
- Raises READY after a fixed post-reset init interval.

Parameters:
DATA_WIDTH, 32, Wishbone data bus width (>=16)
ADDR_WIDTH, 16, Wishbone address bus width
INIT_CYCLES, 4, wb_clk_i cycles after reset deassertion before READY sets (>=1)

Ports:
wb_clk_i  in  1  bus clock; all logic on rising edge
wb_rst_i  in  1  reset, asynchronous, active-high
wb_dat_i  in  DATA_WIDTH  write data
wb_addr_i  in  ADDR_WIDTH  word address
wb_we_i  in  1  1=write, 0=read
wb_stb_i  in  1  transfer request, held by initiator until ack seen
wb_dat_o  out  DATA_WIDTH  read data, valid while wb_ack_o=1
wb_ack_o  out  1  transfer acknowledge, one-cycle pulse
ready_o  out  1  mirror of READY bit
enable_o  out  1  ENABLE[0]
dds_src_o  out  2  DDS_SRC[1:0]: 0 sine, 1 saw, 2 tri, 3 random
tuning_word_o  out  16  phase increment
gain_o  out  2  gain select: x1/x2/x4/x8
offset_o  out  16  output offset
cfg_update_o  out  1  one-cycle pulse after any committed config write

Behaviour:
- Reset (async assert, sync release): wb_ack_o=0, wb_dat_o=0, ready_o=0, enable_o=0, dds_src_o=0, tuning_word_o=16'h0001, gain_o=0, offset_o=16'h00FF, cfg_update_o=0, init counter=0.
- Init counter: increments each cycle after reset release, saturates at INIT_CYCLES. READY sets on the edge the count reaches INIT_CYCLES and stays 1 until the next reset.
- Address map (word addresses): 0 READY (RO), 1 ENABLE, 2 DDS_SRC, 3 TUNING_WORD, 4 GAIN_WORD, 5 OFFSET_WORD.
- Accept condition: accept = wb_stb_i & ~wb_ack_o, sampled on a rising edge.
- On an accept edge:
  - wb_ack_o <= 1.
  - On a write, the register updates on the same edge.
  - On a read, wb_dat_o is loaded on the same edge.
- Latency: ack is visible on the first edge after the strobe is sampled. With stb still high and ack=1 on the next edge, no new accept occurs and ack returns to 0. One strobe therefore yields exactly one ack pulse and one register side-effect.
- Read data: fields are zero-extended to DATA_WIDTH. Unused bits read 0. Unmapped addresses read 0.
- Write masking:
  - Only the implemented field bits are stored: ENABLE[0], DDS_SRC[1:0], TUNING_WORD[15:0], GAIN_WORD[1:0], OFFSET_WORD[15:0]. Upper bits are discarded.
  - Writes to READY or to unmapped addresses are acked and have no effect.
- Writes while ready_o=0 are acked but dropped: no register change, no cfg_update_o.
- cfg_update_o: 1 on the cycle after a committed write to addresses 1-5, otherwise 0. Back-to-back writes give one pulse each.
- wb_dat_o holds its last value when ack=0. Consumers qualify it with ack.
- Reset asserted mid-transaction: ack and all registers return to reset values immediately. A strobe still high after reset release is treated as a new transfer.
- Config outputs are the register values directly; they change on the commit edge.

Test Plan:
- Reset 5 cycles, then poll addr 0 until read=1 -> READY=0 for the first INIT_CYCLES cycles, then 1. Reads of 1-5 -> 0, 0, 0x1, 0, 0xFF.
- Write 0xFFFFFFFF to addrs 0-5, read back -> ENABLE=0x1, DDS_SRC=0x3, TUNING=0xFFFF, GAIN=0x3, OFFSET=0xFFFF, READY=0x1. Outputs match, with one cfg_update_o pulse per write to 1-5.
- Write 0 to addrs 0-5, read back -> all config reads 0, READY still 1.
- Hold stb high for 3 cycles on a TUNING_WORD write -> ack high for exactly 1 cycle, one cfg_update_o pulse. Read/write to addr 7 -> acked, reads 0, no state change.
- Write ENABLE=1 before READY sets -> acked, enable_o stays 0, no cfg_update_o.
- Assert wb_rst_i while ack=1 after an OFFSET write of 0x1234 -> ack=0 and offset_o=0x00FF immediately, READY=0 until INIT_CYCLES elapses again.
